// File: rtl/hc595_chain_if.sv
// Handshake bundle between a word producer and the hc595_chain serializer.
// The producer drives a word plus valid; the serializer answers with ready
// whenever its one-word pending buffer is empty.
interface hc595_chain_if #(
  parameter int W = 16
);
  logic [W-1:0] i_Data;
  logic         i_Valid;
  logic         o_Ready;

  modport master (output i_Data, output i_Valid, input o_Ready);
  modport slave  (input i_Data, input i_Valid, output o_Ready);
endinterface

// File: rtl/hc595_chain.sv
// Serializer for a cascade of 74hc595 shift registers.
// Accepts W-bit words through a one-word pending buffer, shifts them out on
// SER/SRCLK with a programmable half-period, pulses RCLK to latch the frame
// and enables the outputs (OE_n low) once the first complete frame is latched.
module hc595_chain #(
  parameter int N_REGS    = 2,
  parameter int CLK_DIV   = 2,
  parameter int LSB_FIRST = 0
) (
  input  logic         i_clk,
  input  logic         i_Reset,
  hc595_chain_if.slave bus,
  output logic         o_Busy,
  output logic         o_SER,
  output logic         o_SRCLK,
  output logic         o_RCLK,
  output logic         o_OE_n
);

  localparam int W     = 8 * N_REGS;
  localparam int DIV_W = ($clog2(CLK_DIV + 1) < 1) ? 1 : $clog2(CLK_DIV + 1);
  localparam int BIT_W = ($clog2(W) < 1) ? 1 : $clog2(W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LATCH,
    GAP
  } state_t;

  state_t           state_q;
  logic [W-1:0]     pend_q;
  logic [W-1:0]     pend_d;
  logic             pendFull_q;
  logic             pendFull_d;
  logic [W-1:0]     shift_q;
  logic [W-1:0]     shiftAdv_d;
  logic [DIV_W-1:0] divCnt_q;
  logic [BIT_W-1:0] bitCnt_q;
  logic             ser_q;
  logic             srclk_q;
  logic             rclk_q;
  logic             oeN_q;
  logic             accept;
  logic             load;
  logic             firstBit;
  logic             nextBit;
  logic             divLast;

  // Pending buffer next state: a load empties it, an accept fills it, and an
  // accept wins if both happen in the same cycle so the new word is kept.
  always_comb begin
    accept     = bus.i_Valid && !pendFull_q;
    load       = (state_q == IDLE) && pendFull_q;
    pend_d     = pend_q;
    pendFull_d = pendFull_q;
    if (load) begin
      pendFull_d = 1'b0;
    end
    if (accept) begin
      pend_d     = bus.i_Data;
      pendFull_d = 1'b1;
    end
  end

  // Bit-order selection: which end of the word leaves first, and what the
  // shifter looks like after one bit has been sent.
  always_comb begin
    if (LSB_FIRST != 0) begin
      shiftAdv_d = {1'b0, shift_q[W-1:1]};
      firstBit   = pend_q[0];
      nextBit    = shift_q[1];
    end else begin
      shiftAdv_d = {shift_q[W-2:0], 1'b0};
      firstBit   = pend_q[W-1];
      nextBit    = shift_q[W-2];
    end
    divLast = (divCnt_q == DIV_LAST);
  end

  // Pending buffer register; reset empties it and i_Valid is ignored then.
  always_ff @(posedge i_clk) begin
    if (i_Reset) begin
      pend_q     <= '0;
      pendFull_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pendFull_q <= pendFull_d;
    end
  end

  // Frame sequencer with registered pin outputs, so SER/SRCLK/RCLK/OE_n
  // always reflect the state register exactly and never glitch.
  always_ff @(posedge i_clk) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      divCnt_q <= '0;
      bitCnt_q <= '0;
      ser_q    <= 1'b0;
      srclk_q  <= 1'b0;
      rclk_q   <= 1'b0;
      oeN_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          ser_q   <= 1'b0;
          srclk_q <= 1'b0;
          rclk_q  <= 1'b0;
          if (pendFull_q) begin
            shift_q  <= pend_q;
            bitCnt_q <= '0;
            divCnt_q <= '0;
            ser_q    <= firstBit;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          if (divLast) begin
            divCnt_q <= '0;
            srclk_q  <= 1'b1;
            state_q  <= HIGH;
          end else begin
            divCnt_q <= divCnt_q + DIV_ONE;
          end
        end
        HIGH: begin
          if (divLast) begin
            divCnt_q <= '0;
            srclk_q  <= 1'b0;
            if (bitCnt_q == BIT_LAST) begin
              ser_q   <= 1'b0;
              rclk_q  <= 1'b1;
              state_q <= LATCH;
            end else begin
              bitCnt_q <= bitCnt_q + BIT_ONE;
              shift_q  <= shiftAdv_d;
              ser_q    <= nextBit;
              state_q  <= SETUP;
            end
          end else begin
            divCnt_q <= divCnt_q + DIV_ONE;
          end
        end
        LATCH: begin
          if (divLast) begin
            divCnt_q <= '0;
            rclk_q   <= 1'b0;
            oeN_q    <= 1'b0;
            state_q  <= GAP;
          end else begin
            divCnt_q <= divCnt_q + DIV_ONE;
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_Ready = !pendFull_q;
  assign o_Busy      = (state_q != IDLE);
  assign o_SER       = ser_q;
  assign o_SRCLK     = srclk_q;
  assign o_RCLK      = rclk_q;
  assign o_OE_n      = oeN_q;

endmodule

// File: tb/tb_hc595_chain.sv
// Directed bench for hc595_chain: three instances cover MSB-first, LSB-first
// and a single-device fast-clock configuration. A negedge monitor records
// the serial stream and pulse widths; expected values are hand-computed.
module tb_hc595_chain;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] dataIn [3];
  logic [2:0]  validIn = 3'b000;
  logic [2:0]  readyOut;
  logic [2:0]  busyOut;
  logic [2:0]  serOut;
  logic [2:0]  srclkOut;
  logic [2:0]  rclkOut;
  logic [2:0]  oeOut;
  logic        monClear = 1'b1;

  int checks = 0;
  int errors = 0;

  int          srPulses [3];
  int          srRun [3];
  int          srBad [3];
  int          rclkPulses [3];
  int          rclkRun [3];
  int          rclkBad [3];
  int          overlap [3];
  int          serBad [3];
  int          busyRun [3];
  int          busyLen [3];
  int          idleRun [3];
  int          lastIdle [3];
  int          frames [3];
  logic [31:0] capBits [3];
  logic        oeAtRclk [3];
  logic        srPrev [3];
  logic        rclkPrev [3];
  logic        busyPrev [3];

  // 100 MHz-style bench clock; the period is arbitrary for a cycle-based DUT.
  always #5 clk = ~clk;

  hc595_chain_if #(.W(16)) ifA ();
  hc595_chain_if #(.W(16)) ifB ();
  hc595_chain_if #(.W(8))  ifC ();

  assign ifA.i_Data  = dataIn[0];
  assign ifA.i_Valid = validIn[0];
  assign readyOut[0] = ifA.o_Ready;
  assign ifB.i_Data  = dataIn[1];
  assign ifB.i_Valid = validIn[1];
  assign readyOut[1] = ifB.o_Ready;
  assign ifC.i_Data  = dataIn[2][7:0];
  assign ifC.i_Valid = validIn[2];
  assign readyOut[2] = ifC.o_Ready;

  hc595_chain #(.N_REGS(2), .CLK_DIV(2), .LSB_FIRST(0)) dutA (
    .i_clk(clk), .i_Reset(reset), .bus(ifA),
    .o_Busy(busyOut[0]), .o_SER(serOut[0]), .o_SRCLK(srclkOut[0]),
    .o_RCLK(rclkOut[0]), .o_OE_n(oeOut[0])
  );

  hc595_chain #(.N_REGS(2), .CLK_DIV(2), .LSB_FIRST(1)) dutB (
    .i_clk(clk), .i_Reset(reset), .bus(ifB),
    .o_Busy(busyOut[1]), .o_SER(serOut[1]), .o_SRCLK(srclkOut[1]),
    .o_RCLK(rclkOut[1]), .o_OE_n(oeOut[1])
  );

  hc595_chain #(.N_REGS(1), .CLK_DIV(1), .LSB_FIRST(0)) dutC (
    .i_clk(clk), .i_Reset(reset), .bus(ifC),
    .o_Busy(busyOut[2]), .o_SER(serOut[2]), .o_SRCLK(srclkOut[2]),
    .o_RCLK(rclkOut[2]), .o_OE_n(oeOut[2])
  );

  function automatic int halfPeriod(input int idx);
    return (idx == 2) ? 1 : 2;
  endfunction

  // Pin monitor sampled mid-cycle: captures SER at each SRCLK rise, checks
  // pulse widths, clock overlap, SER quiet periods and frame/idle lengths.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (monClear) begin
        srPulses[i]   <= 0;
        srRun[i]      <= 0;
        srBad[i]      <= 0;
        rclkPulses[i] <= 0;
        rclkRun[i]    <= 0;
        rclkBad[i]    <= 0;
        overlap[i]    <= 0;
        serBad[i]     <= 0;
        busyRun[i]    <= 0;
        busyLen[i]    <= 0;
        idleRun[i]    <= 0;
        lastIdle[i]   <= 0;
        frames[i]     <= 0;
        capBits[i]    <= '0;
        oeAtRclk[i]   <= 1'b0;
      end else begin
        if (srclkOut[i] && !srPrev[i]) begin
          srPulses[i] <= srPulses[i] + 1;
          capBits[i]  <= {capBits[i][30:0], serOut[i]};
          srRun[i]    <= 1;
        end else if (srclkOut[i]) begin
          srRun[i] <= srRun[i] + 1;
        end else if (srPrev[i] && srRun[i] != halfPeriod(i)) begin
          srBad[i] <= srBad[i] + 1;
        end
        if (rclkOut[i] && !rclkPrev[i]) begin
          rclkPulses[i] <= rclkPulses[i] + 1;
          oeAtRclk[i]   <= oeOut[i];
          rclkRun[i]    <= 1;
        end else if (rclkOut[i]) begin
          rclkRun[i] <= rclkRun[i] + 1;
        end else if (rclkPrev[i] && rclkRun[i] != halfPeriod(i)) begin
          rclkBad[i] <= rclkBad[i] + 1;
        end
        if (srclkOut[i] && rclkOut[i]) begin
          overlap[i] <= overlap[i] + 1;
        end
        if (serOut[i] && (!busyOut[i] || rclkOut[i])) begin
          serBad[i] <= serBad[i] + 1;
        end
        if (busyOut[i]) begin
          if (!busyPrev[i]) begin
            lastIdle[i] <= idleRun[i];
            busyRun[i]  <= 1;
          end else begin
            busyRun[i] <= busyRun[i] + 1;
          end
        end else begin
          if (busyPrev[i]) begin
            busyLen[i] <= busyRun[i];
            frames[i]  <= frames[i] + 1;
            idleRun[i] <= 1;
          end else begin
            idleRun[i] <= idleRun[i] + 1;
          end
        end
      end
      srPrev[i]   <= srclkOut[i];
      rclkPrev[i] <= rclkOut[i];
      busyPrev[i] <= busyOut[i];
    end
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offers one word to instance idx as soon as it is ready (bounded wait).
  task automatic applyStimulus(input int idx, input logic [15:0] word);
    int waited = 0;
    @(negedge clk);
    while (readyOut[idx] !== 1'b1 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("readyBeforeSend", {31'b0, readyOut[idx]}, 32'd1);
    dataIn[idx]  = word;
    validIn[idx] = 1'b1;
    @(negedge clk);
    validIn[idx] = 1'b0;
  endtask

  task automatic waitFrames(input int idx, input int target, input string tag);
    int waited = 0;
    while (frames[idx] < target && waited < 2000) begin
      @(posedge clk);
      waited++;
    end
    repeat (2) @(posedge clk);
    checkOutput(tag, frames[idx], target);
  endtask

  task automatic clearMon();
    @(posedge clk);
    #1 monClear = 1'b1;
    @(posedge clk);
    #1 monClear = 1'b0;
  endtask

  // Hard stop if the bench itself wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int waited;
    for (int i = 0; i < 3; i++) dataIn[i] = '0;
    validIn[0] = 1'b1;
    dataIn[0]  = 16'hDEAD;

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("resetPins",
                  {26'b0, readyOut[i], busyOut[i], serOut[i], srclkOut[i],
                   rclkOut[i], oeOut[i]},
                  32'b100001);
    end
    @(negedge clk);
    reset      = 1'b0;
    validIn[0] = 1'b0;
    clearMon();
    repeat (5) @(posedge clk);
    #1;
    checkOutput("validIgnoredInReset", {31'b0, busyOut[0]}, 32'd0);
    checkOutput("noFrameAfterReset", frames[0], 0);

    $display("[TB] MSB-first 16'hA5C3");
    clearMon();
    applyStimulus(0, 16'hA5C3);
    waitFrames(0, 1, "frameA5C3");
    checkOutput("serStreamA5C3", capBits[0][15:0], 32'h0000A5C3);
    checkOutput("srclkPulses", srPulses[0], 16);
    checkOutput("srclkWidth", srBad[0], 0);
    checkOutput("rclkPulses", rclkPulses[0], 1);
    checkOutput("rclkWidth", rclkBad[0], 0);
    checkOutput("frameLen67", busyLen[0], 67);
    checkOutput("clockOverlap", overlap[0], 0);
    checkOutput("serQuiet", serBad[0], 0);
    checkOutput("oeHighDuringLatch", {31'b0, oeAtRclk[0]}, 32'd1);
    checkOutput("oeLowAfterLatch", {31'b0, oeOut[0]}, 32'd0);

    $display("[TB] LSB-first words");
    clearMon();
    applyStimulus(1, 16'h0001);
    waitFrames(1, 1, "frame0001");
    checkOutput("lsbFirst0001", capBits[1][15:0], 32'h00008000);
    checkOutput("lsbPulses", srPulses[1], 16);
    applyStimulus(1, 16'hA5C3);
    waitFrames(1, 2, "frameLsbA5C3");
    checkOutput("lsbFirstA5C3", capBits[1][15:0], 32'h0000C3A5);
    checkOutput("lsbFrameLen", busyLen[1], 67);

    $display("[TB] back-to-back words with held valid");
    clearMon();
    applyStimulus(0, 16'h1234);
    applyStimulus(0, 16'hFFFF);
    dataIn[0]  = 16'h0F0F;
    validIn[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 checkOutput("readyLowWhileFull", {31'b0, readyOut[0]}, 32'd0);
    end
    @(negedge clk);
    validIn[0] = 1'b0;
    waitFrames(0, 2, "twoFrames");
    checkOutput("b2bStream", capBits[0], 32'h1234FFFF);
    checkOutput("b2bPulses", srPulses[0], 32);
    checkOutput("b2bRclk", rclkPulses[0], 2);
    checkOutput("b2bIdleGap", lastIdle[0], 1);
    checkOutput("b2bFrameLen", busyLen[0], 67);
    repeat (150) @(posedge clk);
    checkOutput("noExtraFrame", frames[0], 2);

    $display("[TB] reset mid-frame");
    clearMon();
    applyStimulus(0, 16'hFFFF);
    waited = 0;
    while (srPulses[0] < 5 && waited < 500) begin
      @(posedge clk);
      waited++;
    end
    checkOutput("reachedPulse5", srPulses[0], 5);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 checkOutput("midFrameResetPins",
                   {26'b0, readyOut[0], busyOut[0], serOut[0], srclkOut[0],
                    rclkOut[0], oeOut[0]},
                   32'b100001);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("abortNoRclk", rclkPulses[0], 0);
    checkOutput("abortOeHigh", {31'b0, oeOut[0]}, 32'd1);
    clearMon();
    applyStimulus(0, 16'h8001);
    waitFrames(0, 1, "frameAfterAbort");
    checkOutput("restartStream", capBits[0][15:0], 32'h00008001);
    checkOutput("restartPulses", srPulses[0], 16);
    checkOutput("restartRclk", rclkPulses[0], 1);

    $display("[TB] single device, divider 1");
    clearMon();
    applyStimulus(2, 16'h0080);
    waitFrames(2, 1, "frame80");
    checkOutput("stream80", capBits[2][7:0], 32'h00000080);
    checkOutput("pulses8", srPulses[2], 8);
    checkOutput("width1", srBad[2], 0);
    checkOutput("frameLen18", busyLen[2], 18);
    checkOutput("rclkWidth1", rclkBad[2], 0);
    checkOutput("fastOverlap", overlap[2], 0);
    checkOutput("fastOeLow", {31'b0, oeOut[2]}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
